fd_delay_line_arbiter: RTL

Shares one 10-bit delay-chip programming bus between g_NUM_CHANNELS programmable delay lines; each delay chip has its own latch-enable (LEN). Each delay chip latches the bus on the rising edge of its LEN.
Per-channel update requests are captured and served round-robin. The block drives the bus with programmable setup, LEN-high and hold times, so every chip latches a stable value.
Sits between the per-channel fine-delay register logic and the delay-chip pins on the card.

---
 rtl/fd_delay_line_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fd_delay_line_arbiter.sv
// Round-robin arbiter sharing one 10-bit delay-chip bus between per-channel LEN lines.
// Optional per-channel readback of the last latched value: define FD_DLY_READBACK_EN.
module fd_delay_line_arbiter #(
  parameter int g_NUM_CHANNELS = 4,
  parameter int g_SETUP_CYCLES = 2,
  parameter int g_LEN_CYCLES   = 2,
  parameter int g_HOLD_CYCLES  = 2
) (
  input  logic                         clk_ref_i,
  input  logic                         rst_n_i,
  input  logic [g_NUM_CHANNELS-1:0]    req_i,
  input  logic [10*g_NUM_CHANNELS-1:0] delay_i,
  output logic [9:0]                   delay_bus_o,
  output logic [g_NUM_CHANNELS-1:0]    len_o,
  output logic [g_NUM_CHANNELS-1:0]    done_p_o,
  output logic                         busy_o,
  output logic [g_NUM_CHANNELS-1:0]    pending_o,
  output logic [10*g_NUM_CHANNELS-1:0] cur_delay_o
);

  localparam int N    = g_NUM_CHANNELS;
  localparam int PW   = (N > 1) ? $clog2(N) : 1;
  localparam int MAXC = (g_SETUP_CYCLES > g_LEN_CYCLES)
                        ? ((g_SETUP_CYCLES > g_HOLD_CYCLES) ? g_SETUP_CYCLES : g_HOLD_CYCLES)
                        : ((g_LEN_CYCLES > g_HOLD_CYCLES) ? g_LEN_CYCLES : g_HOLD_CYCLES);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          sel_q, sel_d, rr_ptr_q, rr_ptr_d;
  logic [N-1:0]           pending_q, pending_d, len_q, len_d, done_q, done_d;
  logic [N-1:0][9:0]      cap_q, cap_d;
  logic [9:0]             bus_q, bus_d;
  logic                   grant_valid;
  logic [PW-1:0]          grant_sel;
  logic [2*N-1:0]         pend_rot;
  logic                   hold_done;

  // Rotating the doubled pending vector puts rr_ptr at bit 0, so the search is a fixed priority scan.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = '0;
    pend_rot    = {pending_q, pending_q} >> rr_ptr_q;
    for (int i = 0; i < N; i++) begin
      if (!grant_valid && pend_rot[i]) begin
        grant_valid = 1'b1;
        grant_sel   = PW'((int'(rr_ptr_q) + i) % N);
      end
    end
  end

  assign hold_done = (state_q == ST_HOLD) && (cnt_q == '0);

  always_comb begin
    // NOTE: every signal gets a default at the top so no path through the case leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    rr_ptr_d  = rr_ptr_q;
    bus_d     = bus_q;
    pending_d = pending_q;
    cap_d     = cap_q;
    done_d    = '0;
    len_d     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d              = ST_SETUP;
          cnt_d                = CW'(g_SETUP_CYCLES - 1);
          sel_d                = grant_sel;
          bus_d                = cap_q[grant_sel];
          pending_d[grant_sel] = 1'b0;
          rr_ptr_d             = (int'(grant_sel) == N - 1) ? '0 : grant_sel + PW'(1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = CW'(g_LEN_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CW'(g_HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d       = ST_IDLE;
          done_d[sel_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh request wins over the grant-time clear, so a same-edge re-request stays pending.
    for (int k = 0; k < N; k++) begin
      if (req_i[k]) begin
        pending_d[k] = 1'b1;
        cap_d[k]     = delay_i[10*k +: 10];
      end
    end

    if (state_d == ST_STROBE) len_d[sel_d] = 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      rr_ptr_q  <= '0;
      bus_q     <= '0;
      pending_q <= '0;
      len_q     <= '0;
      done_q    <= '0;
      // NOTE: the capture array is reset too; it is small and a stale value must never reach a chip.
      cap_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      rr_ptr_q  <= rr_ptr_d;
      bus_q     <= bus_d;
      pending_q <= pending_d;
      len_q     <= len_d;
      done_q    <= done_d;
      cap_q     <= cap_d;
    end
  end

`ifdef FD_DLY_READBACK_EN
  logic [N-1:0][9:0] cur_q, cur_d;

  always_comb begin
    cur_d = cur_q;
    if (hold_done) cur_d[sel_q] = bus_q;
  end

  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) cur_q <= '0;
    else          cur_q <= cur_d;
  end

  assign cur_delay_o = cur_q;
`else
  assign cur_delay_o = '0;
`endif

  assign delay_bus_o = bus_q;
  assign len_o       = len_q;
  assign done_p_o    = done_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign pending_o   = pending_q;

endmodule
